mfp_adc_max10_avg: RTL

- Per-channel decimating averager placed directly downstream of the MAX10 ADC IP response port (Avalon-ST `response_*`). It sits in parallel with, or ahead of, the ADC control core's result capture.
- Accumulates 2^AVG_LOG2 consecutive 12-bit samples per channel and emits one averaged 12-bit result per channel per window on a valid/ready output stream.
- Intended to offload software averaging for noisy analog inputs (pots, temperature sensor).

---
 rtl/mfp_adc_max10_avg.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mfp_adc_max10_avg.sv
// Per-channel decimating averager for the MAX10 ADC response stream.
// Optional round-half-up with saturation when MFP_ADC_AVG_ROUND_EN is defined.
module mfp_adc_max10_avg #(
    parameter int CH_NUM   = 17,
    parameter int AVG_LOG2 = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ADC_R_Valid,
    input  logic [4:0]  ADC_R_Channel,
    input  logic [11:0] ADC_R_Data,
    input  logic        flush,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic [4:0]  avg_channel,
    output logic [11:0] avg_data,
    output logic        overrun,
    output logic        bad_channel
);
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc [CH_NUM];
    logic [CNT_W-1:0] r_cnt [CH_NUM];
    logic             r_avg_valid;
    logic [4:0]       r_avg_channel;
    logic [11:0]      r_avg_data;
    logic             r_overrun;
    logic             r_bad_channel;

    logic             w_in_range;
    logic             w_last;
    logic [ACC_W-1:0] w_acc_cur;
    logic [ACC_W-1:0] w_sum;
    logic [11:0]      w_result;
    logic             w_offer;
    logic             w_load;

    assign w_in_range = (32'(ADC_R_Channel) < CH_NUM);

    // Out-of-range channels must never index the per-channel arrays.
    always_comb begin
        w_acc_cur = '0;
        w_last    = 1'b0;
        if (w_in_range) begin
            w_acc_cur = r_acc[ADC_R_Channel];
            w_last    = (r_cnt[ADC_R_Channel] == CNT_LAST);
        end
    end

    assign w_sum   = w_acc_cur + ACC_W'(ADC_R_Data);
    assign w_offer = ADC_R_Valid && !flush && w_in_range && w_last;
    assign w_load  = w_offer && (!r_avg_valid || avg_ready);

`ifdef MFP_ADC_AVG_ROUND_EN
    generate
        if (AVG_LOG2 > 0) begin : g_round
            // Adding half an LSB before the shift equals adding the first dropped bit after it.
            logic [12:0] w_rnd;
            assign w_rnd    = {1'b0, w_sum[ACC_W-1:AVG_LOG2]} + 13'(w_sum[AVG_LOG2-1]);
            assign w_result = w_rnd[12] ? 12'hFFF : w_rnd[11:0];
        end else begin : g_pass
            assign w_result = w_sum[11:0];
        end
    endgenerate
`else
    assign w_result = w_sum[ACC_W-1:AVG_LOG2];
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_avg_valid   <= 1'b0;
            r_avg_channel <= '0;
            r_avg_data    <= '0;
            r_overrun     <= 1'b0;
            r_bad_channel <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    r_acc[i] <= '0;
                    r_cnt[i] <= '0;
                end
                r_overrun     <= 1'b0;
                r_bad_channel <= 1'b0;
            end else if (ADC_R_Valid) begin
                if (!w_in_range) begin
                    r_bad_channel <= 1'b1;
                end else if (w_last) begin
                    r_acc[ADC_R_Channel] <= '0;
                    r_cnt[ADC_R_Channel] <= '0;
                end else begin
                    r_acc[ADC_R_Channel] <= w_sum;
                    r_cnt[ADC_R_Channel] <= r_cnt[ADC_R_Channel] + CNT_W'(1);
                end
            end

            if (w_load) begin
                r_avg_valid   <= 1'b1;
                r_avg_channel <= ADC_R_Channel;
                r_avg_data    <= w_result;
            end else if (r_avg_valid && avg_ready) begin
                r_avg_valid <= 1'b0;
            end

            // w_offer already excludes flush, so this cannot fight the flush clear.
            if (w_offer && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign avg_valid   = r_avg_valid;
    assign avg_channel = r_avg_channel;
    assign avg_data    = r_avg_data;
    assign overrun     = r_overrun;
    assign bad_channel = r_bad_channel;

endmodule
